toggle_event_decoder: RTL

//  Receiving end of the toggle-encoded event line driven by the flipflopT stage.

---
 rtl/toggle_event_decoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: receives a toggle-encoded event line. It synchronises
// t_in, emits one event_pulse per level change, counts events (with a sticky
// wrap flag) and flags a line that has stopped toggling while enabled.
//
// Handshake note: there is no valid/ready pair here. t_in is a level-change
// stream with no back-pressure, and every detected change is reported on
// event_pulse for exactly one clock. Downstream logic must take event_pulse
// on the cycle it is high; nothing is held or queued.
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_in,
  input  logic             enable,
  input  logic             clear,
  output logic             level,
  output logic             event_pulse,
  output logic [CNT_W-1:0] event_count,
  output logic             overflow,
  output logic             stuck,
  output logic [1:0]       state_dbg
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int WAIT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_REF = 2'd0,
    ACTIVE   = 2'd1,
    STUCK    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   stuck_q, stuck_d;
  logic                   pulse_q, pulse_d;
  logic                   edge_det;

  // Synchroniser on the asynchronous event line; prev lags it by one cycle so
  // any level change shows up as a single-cycle edge_det.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level    = sync_q[SYNC_STAGES-1];
  assign edge_det = level ^ prev_q;

  // State and datapath registers, all loaded from the next-state logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_REF;
      wait_q  <= '0;
      idle_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      stuck_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idle_q  <= idle_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      stuck_q <= stuck_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. WAIT_REF lets the sync chain and prev settle on the
  // real line level after reset so an idle-high line yields no false event.
  // clear is applied last so it wins over a same-cycle count.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idle_d  = idle_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    stuck_d = stuck_q;
    pulse_d = 1'b0;

    case (state_q)
      WAIT_REF: begin
        if (wait_q == WAIT_W'(SYNC_STAGES)) begin
          state_d = ACTIVE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ACTIVE, STUCK: begin
        if (enable) begin
          if (edge_det) begin
            pulse_d = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == {CNT_W{1'b1}}) begin
              ovf_d = 1'b1;
            end
            idle_d  = '0;
            stuck_d = 1'b0;
            state_d = ACTIVE;
          end else if (state_q == ACTIVE) begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_W'(TIMEOUT)) begin
              stuck_d = 1'b1;
              state_d = STUCK;
            end
          end
        end else begin
          // Disabled: level is still tracked via prev, idle time is not.
          idle_d = '0;
        end
      end
      default: begin
        state_d = WAIT_REF;
      end
    endcase

    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      stuck_d = 1'b0;
      idle_d  = '0;
      if (state_d == STUCK) begin
        state_d = ACTIVE;
      end
    end
  end

  assign event_pulse = pulse_q;
  assign event_count = count_q;
  assign overflow    = ovf_q;
  assign stuck       = stuck_q;
  assign state_dbg   = state_q;

endmodule
